// File: rtl/a26_pkg.sv
// rtl/a26_pkg.sv - shared types and threshold helper for the paddle pot emulation
package a26_pkg;

    localparam int PAD_CNT_W = 9;

    typedef enum logic [1:0] {
        DUMPED   = 2'd0,
        CHARGING = 2'd1,
        CHARGED  = 2'd2
    } pad_state_t;

    // Charge time in scanlines: fixed minimum plus 1.5 lines per position unit.
    function automatic logic [PAD_CNT_W-1:0] pad_thresh(
        input logic [7:0]           pos,
        input logic [PAD_CNT_W-1:0] min_lines
    );
        return min_lines + {1'b0, pos} + {2'b00, pos[7:1]};
    endfunction

endpackage

// File: rtl/a26_pot_channel.sv
// rtl/a26_pot_channel.sv - one paddle pot: dump/charge FSM, scanline counter and threshold latch
module a26_pot_channel
    import a26_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 line_stb,
    input  logic                 dump,
    input  logic [PAD_CNT_W-1:0] thresh,
    output logic                 pad_out
);

    pad_state_t           state, state_n;
    logic [PAD_CNT_W-1:0] count, count_n;
    logic [PAD_CNT_W-1:0] thr_q, thr_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= DUMPED;
            count   <= '0;
            thr_q   <= '0;
            pad_out <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            thr_q   <= thr_n;
            // Decoded from next state so the comparator drops on the same edge dump is seen.
            pad_out <= (state_n == CHARGED);
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        thr_n   = thr_q;
        case (state)
            DUMPED: begin
                count_n = '0;
                if (!dump) begin
                    state_n = CHARGING;
                    thr_n   = thresh;
                end
            end
            CHARGING: begin
                if (line_stb && (count != {PAD_CNT_W{1'b1}}))
                    count_n = count + 1'b1;
                if (count >= thr_q)
                    state_n = CHARGED;
            end
            CHARGED: ;
            default: state_n = DUMPED;
        endcase
        if (dump) begin
            state_n = DUMPED;
            count_n = '0;
        end
    end

endmodule

// File: rtl/a26_paddle_emu.sv
// rtl/a26_paddle_emu.sv - four paddle pot emulators with analog or digital-integrator position sources
module a26_paddle_emu
    import a26_pkg::*;
#(
    parameter int MIN_LINES  = 8,
    parameter int STEP_LINES = 262,
    parameter int STEP       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        line_stb,
    input  logic        dump,
    input  logic [31:0] pos_in,
    input  logic        dig_mode,
    input  logic [3:0]  joy_left,
    input  logic [3:0]  joy_right,
    output logic [3:0]  pad_out,
    output logic [31:0] pos_dbg
);

    localparam int STEP_W = (STEP_LINES > 1) ? $clog2(STEP_LINES) : 1;

    logic [STEP_W-1:0] step_cnt;
    logic              step_wrap;

    assign step_wrap = line_stb && (step_cnt == STEP_W'(STEP_LINES - 1));

    // Frame-rate tick for the joystick integrators; free-running so switching modes is seamless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            step_cnt <= '0;
        else if (step_wrap)
            step_cnt <= '0;
        else if (line_stb)
            step_cnt <= step_cnt + 1'b1;
    end

    for (genvar n = 0; n < 4; n++) begin : g_ch
        logic [7:0] pos_d;
        logic [7:0] pos_e;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pos_d <= 8'h80;
            end else if (step_wrap) begin
                if (joy_right[n] && !joy_left[n])
                    pos_d <= (pos_d > 8'(255 - STEP)) ? 8'hff : pos_d + 8'(STEP);
                else if (joy_left[n] && !joy_right[n])
                    pos_d <= (pos_d < 8'(STEP)) ? 8'h00 : pos_d - 8'(STEP);
            end
        end

        assign pos_e              = dig_mode ? pos_d : pos_in[8*n +: 8];
        assign pos_dbg[8*n +: 8]  = pos_e;

        a26_pot_channel u_pot (
            .clk      (clk),
            .reset_n  (reset_n),
            .line_stb (line_stb),
            .dump     (dump),
            .thresh   (pad_thresh(pos_e, PAD_CNT_W'(MIN_LINES))),
            .pad_out  (pad_out[n])
        );
    end

endmodule
